mips_control: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. Each instruction is walked through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states, and the block drives every datapath enable: PC advance, instruction latch, register-file write, ALU operand select, data-memory request/write and jump. It sits between instruction memory/decode and the pc, register_file, alu and data_memory blocks. It replaces the per-opcode combinational enables with a sequenced, stall-capable controller that traps on illegal opcodes and memory timeouts.

---
 rtl/mips_control_if.sv | 30 +++
 rtl/mips_control.sv | 67 ++++++
 tb/tb_mips_control.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_control_if.sv
// mips_control_if: signal bundle between the control sequencer (master) and the datapath (slave).
interface mips_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic alu_zero;
  logic dmem_ack;
  logic ir_load;
  logic pc_en;
  logic jmp;
  logic alu_src_imm;
  logic reg_write_enable;
  logic reg_dst_rd;
  logic mem_to_reg;
  logic dmem_req;
  logic dmem_write;
  logic trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
  logic [31:0] instret;
  modport master (
    input opcode, funct, alu_zero, dmem_ack,
    output ir_load, pc_en, jmp, alu_src_imm, reg_write_enable, reg_dst_rd,
    output mem_to_reg, dmem_req, dmem_write, trap, trap_cause, state, instret
  );
  modport slave (
    output opcode, funct, alu_zero, dmem_ack,
    input ir_load, pc_en, jmp, alu_src_imm, reg_write_enable, reg_dst_rd,
    input mem_to_reg, dmem_req, dmem_write, trap, trap_cause, state, instret
  );
endinterface

// File: rtl/mips_control.sv
// mips_control: multi-cycle MIPS control sequencer with illegal-opcode and memory-timeout traps.
module mips_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  mips_control_if.master bus
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WRITEBACK = 3'd4, TRAP = 3'd7
  } state_t;
  state_t cur, nxt;
  logic [5:0] op;
  logic [7:0] wait_cnt;
  logic [1:0] cause;
  logic legal, is_r, is_j, is_beq, is_lw, is_sw, is_imm;
  assign legal = (bus.opcode == 6'h00) ? (bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a})
                                       : (bus.opcode inside {6'h02, 6'h04, 6'h08, 6'h0f, 6'h23, 6'h2b});
  assign is_r = op == 6'h00;
  assign is_j = op == 6'h02;
  assign is_beq = op == 6'h04;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2b;
  assign is_imm = op inside {6'h08, 6'h0f, 6'h23, 6'h2b};
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= FETCH;
      op <= '0;
      wait_cnt <= '0;
      cause <= '0;
      bus.instret <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op <= bus.opcode;
      cause <= (cur == DECODE && nxt == TRAP) ? 2'd1 : (cur == MEM && nxt == TRAP) ? 2'd2 : cause;
      wait_cnt <= (cur == MEM && nxt == MEM) ? wait_cnt + 8'd1 : '0;
      if (bus.pc_en) bus.instret <= bus.instret + 32'd1;
    end
  end
  // an ack in the last allowed MEM cycle still completes the access
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE: nxt = legal ? EXECUTE : TRAP;
      EXECUTE: nxt = (is_j || is_beq) ? FETCH : (is_lw || is_sw) ? MEM : WRITEBACK;
      MEM: nxt = bus.dmem_ack ? (is_sw ? FETCH : WRITEBACK)
                              : (wait_cnt == 8'(MEM_TIMEOUT - 1)) ? TRAP : MEM;
      WRITEBACK: nxt = FETCH;
      default: nxt = TRAP;
    endcase
  end
  always_comb begin
    bus.ir_load = cur == FETCH && !rst;
    bus.pc_en = (cur == EXECUTE && (is_j || is_beq)) || (cur == MEM && is_sw && bus.dmem_ack) || cur == WRITEBACK;
    bus.jmp = cur == EXECUTE && (is_j || (is_beq && bus.alu_zero));
    bus.alu_src_imm = is_imm && cur inside {EXECUTE, MEM, WRITEBACK};
    bus.reg_write_enable = cur == WRITEBACK;
    bus.reg_dst_rd = cur == WRITEBACK && is_r;
    bus.mem_to_reg = cur == WRITEBACK && is_lw;
    bus.dmem_req = cur == MEM;
    bus.dmem_write = cur == MEM && is_sw;
    bus.trap = cur == TRAP;
    bus.trap_cause = cause;
    bus.state = cur;
  end
endmodule

// File: tb/tb_mips_control.sv
// tb_mips_control: randomized instruction streams checked cycle by cycle against a phase-based timing model.
module tb_mips_control;
  localparam int TO = 15;
  logic clk, rst;
  int checks = 0, errors = 0;
  logic [31:0] instret_m;
  logic [14:0] outs;
  mips_control_if bus ();
  mips_control #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign outs = {bus.ir_load, bus.pc_en, bus.jmp, bus.alu_src_imm, bus.reg_write_enable, bus.reg_dst_rd,
                 bus.mem_to_reg, bus.dmem_req, bus.dmem_write, bus.trap, bus.trap_cause, bus.state};
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction
  function automatic logic rb();
    return 1'($urandom);
  endfunction
  // expected output vector: ir,pc,jmp,imm,rwe,rd,m2r,req,wr,trap,cause,state
  function automatic logic [14:0] mk(input bit ir, pc, jp, im, rw, rd, mr, rq, wr, tr,
                                     input logic [1:0] c, input logic [2:0] s);
    return {ir, pc, jp, im, rw, rd, mr, rq, wr, tr, c, s};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [5:0] o, input logic [5:0] f, input logic az,
                     input logic ack, input logic [14:0] exp);
    bus.opcode = o;
    bus.funct = f;
    bus.alu_zero = az;
    bus.dmem_ack = ack;
    #2;
    check(tag, 32'(outs), 32'(exp));
    check({tag, ".instret"}, bus.instret, instret_m);
    if (exp[13]) instret_m++;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    bus.dmem_ack = rb();
    bus.opcode = r6();
    @(posedge clk);
    #1;
    instret_m = 0;
    #2;
    check("reset", 32'(outs), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0)));
    check("reset.instret", bus.instret, instret_m);
    rst = 0;
  endtask
  // one instruction; d = MEM cycles without ack before the ack (d >= TO means never)
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic az, input int d,
                           output logic [1:0] tc);
    bit r = op == 6'h00, j = op == 6'h02, beq = op == 6'h04, lw = op == 6'h23, sw = op == 6'h2b;
    bit im = op inside {6'h08, 6'h0f, 6'h23, 6'h2b};
    bit ok = (r && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) || j || beq || im;
    int mem_n = (d < TO) ? d + 1 : TO;
    tc = 0;
    cyc("fetch", r6(), r6(), rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("decode", op, fn, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,0,1));
    if (!ok) begin
      cyc("trap_illegal", r6(), r6(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,1,7));
      tc = 1;
      return;
    end
    if (j || beq) begin
      cyc("exec_branch", r6(), r6(), az, rb(), mk(0,1,j | az,0,0,0,0,0,0,0,0,2));
      return;
    end
    cyc("exec", r6(), r6(), az, rb(), mk(0,0,0,im,0,0,0,0,0,0,0,2));
    if (lw || sw) begin
      for (int i = 0; i < mem_n; i++)
        cyc("mem", r6(), r6(), rb(), i == d, mk(0,sw && i == d,0,1,0,0,0,1,sw,0,0,3));
      if (d >= TO) begin
        cyc("trap_timeout", r6(), r6(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,2,7));
        tc = 2;
        return;
      end
      if (sw) return;
    end
    cyc("writeback", r6(), r6(), rb(), rb(), mk(0,1,0,im,1,r,lw,0,0,0,0,4));
  endtask
  task automatic trap_hold(input logic [1:0] c);
    for (int i = 0; i < 3; i++)
      cyc("trap_hold", r6(), r6(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,c,7));
  endtask
  initial begin
    logic [1:0] tc;
    logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0f, 6'h23, 6'h2b, 6'h00};
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    rst = 1;
    bus.alu_zero = 0;
    bus.funct = 0;
    instret_m = 0;
    do_reset();
    run_instr(6'h0f, r6(), rb(), 0, tc);
    run_instr(6'h08, r6(), rb(), 0, tc);
    run_instr(6'h02, r6(), rb(), 0, tc);
    run_instr(6'h04, r6(), 1'b0, 0, tc);
    run_instr(6'h04, r6(), 1'b1, 0, tc);
    run_instr(6'h23, r6(), rb(), 3, tc);
    run_instr(6'h2b, r6(), rb(), 0, tc);
    run_instr(6'h2b, r6(), rb(), TO - 1, tc);
    run_instr(6'h00, 6'h2a, rb(), 0, tc);
    run_instr(6'h3f, r6(), rb(), 0, tc);
    trap_hold(tc);
    do_reset();
    run_instr(6'h00, 6'h01, rb(), 0, tc);
    trap_hold(tc);
    do_reset();
    run_instr(6'h08, r6(), rb(), 0, tc);
    run_instr(6'h2b, r6(), rb(), TO, tc);
    trap_hold(tc);
    do_reset();
    cyc("abort.fetch", r6(), r6(), rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0,0,0));
    cyc("abort.decode", 6'h2b, r6(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,0,1));
    cyc("abort.exec", r6(), r6(), rb(), rb(), mk(0,0,0,1,0,0,0,0,0,0,0,2));
    cyc("abort.mem", r6(), r6(), rb(), 1'b0, mk(0,0,0,1,0,0,0,1,1,0,0,3));
    do_reset();
    force bus.instret = 32'hFFFF_FFFF;
    instret_m = 32'hFFFF_FFFF;
    #1;
    release bus.instret;
    run_instr(6'h02, r6(), rb(), 0, tc);
    run_instr(6'h00, 6'h20, rb(), 0, tc);
    for (int n = 0; n < 80; n++) begin
      int s = $urandom_range(0, 19);
      logic [5:0] o = (s < 16) ? ops[s % 8] : r6();
      logic [5:0] f = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : r6();
      int d = ($urandom_range(0, 9) == 0) ? (rb() ? TO - 1 : TO) : $urandom_range(0, 3);
      run_instr(o, f, rb(), d, tc);
      if (tc != 0) begin
        trap_hold(tc);
        do_reset();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
